button_gesture_decoder: RTL and testbench

BUTTON_GESTURE_DECODER -- requirements
Module: Button_Gesture_Decoder

---
 rtl/button_gesture_decoder_pkg.sv | 24 ++
 rtl/button_gesture_decoder_edge_detect.sv | 27 ++
 rtl/button_gesture_decoder.sv | 174 +++++++++++++++++
 tb/tb_button_gesture_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/button_gesture_decoder_pkg.sv
// Shared definitions for the button gesture decoder: FSM state encoding,
// default timing limits and a small constant helper for counter sizing.
package Button_Pkg;

    localparam int LONG_PRESS_LIMIT_DEF   = 25000000;
    localparam int DOUBLE_CLICK_LIMIT_DEF = 5000000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HELD      = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        HELD_2ND  = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/button_gesture_decoder_edge_detect.sv
// Edge_Detect: registers the debounced switch once and flags rising/falling
// edges by comparing the live input with that one-cycle-delayed copy.
module Edge_Detect (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Prev,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_Prev;

    // Delay the switch by one clock; reset clears it so a held switch reads as a rise.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Prev <= 1'b0;
        end else begin
            r_Prev <= i_Switch;
        end
    end

    assign o_Prev = r_Prev;
    assign o_Rise = i_Switch & ~r_Prev;
    assign o_Fall = ~i_Switch & r_Prev;

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies presses of a debounced button into short, long and double-click
// pulses. Double-click support is enabled by defining BUTTON_DOUBLE_CLICK_EN.
module button_gesture_decoder
    import Button_Pkg::*;
#(
    parameter int LONG_PRESS_LIMIT   = LONG_PRESS_LIMIT_DEF,
    parameter int DOUBLE_CLICK_LIMIT = DOUBLE_CLICK_LIMIT_DEF
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Pressed,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Double_Click
);

    localparam int CNT_W = $clog2(max_int(LONG_PRESS_LIMIT, DOUBLE_CLICK_LIMIT) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_LIMIT - 1);
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DOUBLE_CLICK_LIMIT - 1);
`endif

    logic             prev;
    logic             rise;
    logic             fall;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             short_q;
    logic             long_q;

    Edge_Detect u_edge (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_Prev   (prev),
        .o_Rise   (rise),
        .o_Fall   (fall)
    );

    // Saturating increment so a stuck state can never wrap the timer.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

`ifdef BUTTON_DOUBLE_CLICK_EN
    logic dbl_q;

    // Gesture FSM with registered one-cycle pulses; the counter restarts on every state change.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_q <= WAIT_2ND;
                        cnt_q   <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state_q <= LONG_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                // A rise in the timeout cycle still wins over the short-press verdict.
                WAIT_2ND: begin
                    if (rise) begin
                        state_q <= HELD_2ND;
                        cnt_q   <= '0;
                    end else if (cnt_q == DC_LAST) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                HELD_2ND: begin
                    if (fall) begin
                        dbl_q   <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_Double_Click = dbl_q;
`else
    // Gesture FSM without double-click: a release before the long limit is a short press.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state_q <= LONG_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_Double_Click = 1'b0;
`endif

    assign o_Pressed     = prev;
    assign o_Short_Press = short_q;
    assign o_Long_Press  = long_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with LONG_PRESS_LIMIT=8 and
// DOUBLE_CLICK_LIMIT=4; expectations follow BUTTON_DOUBLE_CLICK_EN.
module tb_button_gesture_decoder;

    localparam logic [2:0] K_N = 3'b000;
    localparam logic [2:0] K_S = 3'b100;
    localparam logic [2:0] K_L = 3'b010;
    localparam logic [2:0] K_D = 3'b001;

    typedef struct {
        logic       sw;
        int         reps;
        int         pulse_at;
        logic [2:0] kind;
    } vec_t;

    logic clk;
    logic rst;
    logic sw;
    logic o_pressed;
    logic o_short;
    logic o_long;
    logic o_dbl;
    logic [3:0] outs;
    int checks;
    int errors;
    vec_t vt[$];

    assign outs = {o_pressed, o_short, o_long, o_dbl};

    button_gesture_decoder #(
        .LONG_PRESS_LIMIT   (8),
        .DOUBLE_CLICK_LIMIT (4)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Switch       (sw),
        .o_Pressed      (o_pressed),
        .o_Short_Press  (o_short),
        .o_Long_Press   (o_long),
        .o_Double_Click (o_dbl)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input int r, input int at, input logic [2:0] k);
        vec_t v;
        v.sw       = s;
        v.reps     = r;
        v.pulse_at = at;
        v.kind     = k;
        return v;
    endfunction

    task automatic chk(input string name, input int vid, input int cyc,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d cyc%0d: got {pressed,short,long,dbl}=%b want %b",
                     name, vid, cyc, act, exp);
        end
    endtask

    // Drive one record for its repeat count, checking outputs just after each edge.
    task automatic apply(input vec_t v, input int vid);
        logic [3:0] exp;
        for (int i = 0; i < v.reps; i++) begin
            sw = v.sw;
            @(posedge clk);
            #1;
            exp = {v.sw, (i == v.pulse_at) ? v.kind : K_N};
            chk("vec", vid, i, outs, exp);
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        sw     = 1'b0;
        checks = 0;
        errors = 0;

        #3;
        chk("reset", 0, 0, outs, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // short press: 3 cycles held, then release
        vt.push_back(mk(1'b0, 2, -1, K_N));
        vt.push_back(mk(1'b1, 3, -1, K_N));
`ifdef BUTTON_DOUBLE_CLICK_EN
        vt.push_back(mk(1'b0, 12, 4, K_S));
`else
        vt.push_back(mk(1'b0, 12, 0, K_S));
`endif
        // long press: held 20 cycles, release silent
        vt.push_back(mk(1'b1, 20, 8, K_L));
        vt.push_back(mk(1'b0, 8, -1, K_N));
        // press 2, release 2, press 2, release
        vt.push_back(mk(1'b1, 2, -1, K_N));
`ifdef BUTTON_DOUBLE_CLICK_EN
        vt.push_back(mk(1'b0, 2, -1, K_N));
        vt.push_back(mk(1'b1, 2, -1, K_N));
        vt.push_back(mk(1'b0, 8, 0, K_D));
`else
        vt.push_back(mk(1'b0, 2, 0, K_S));
        vt.push_back(mk(1'b1, 2, -1, K_N));
        vt.push_back(mk(1'b0, 8, 0, K_S));
`endif
        // fall in the same cycle the counter hits 7: short path wins
        vt.push_back(mk(1'b1, 8, -1, K_N));
`ifdef BUTTON_DOUBLE_CLICK_EN
        vt.push_back(mk(1'b0, 12, 4, K_S));
`else
        vt.push_back(mk(1'b0, 12, 0, K_S));
`endif
        // second rise in the timeout cycle of the double-click window
        vt.push_back(mk(1'b1, 2, -1, K_N));
`ifdef BUTTON_DOUBLE_CLICK_EN
        vt.push_back(mk(1'b0, 4, -1, K_N));
        vt.push_back(mk(1'b1, 3, -1, K_N));
        vt.push_back(mk(1'b0, 6, 0, K_D));
`else
        vt.push_back(mk(1'b0, 4, 0, K_S));
        vt.push_back(mk(1'b1, 3, -1, K_N));
        vt.push_back(mk(1'b0, 6, 0, K_S));
`endif

        foreach (vt[k]) begin
            apply(vt[k], k + 1);
        end

        // reset mid-HELD at count 5 with the switch still down
        apply(mk(1'b1, 6, -1, K_N), 100);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_held", 100, 6, outs, 4'b0000);
        @(posedge clk);
        #1;
        chk("in_rst", 100, 7, outs, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1'b1, 9, 8, K_L), 101);

        // reset while the long pulse is high drops it at once
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pulse", 101, 9, outs, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1'b0, 6, -1, K_N), 102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
